// File: rtl/matrix_pwm_driver.sv
// ROWS x COLS RGB matrix driver for chained 595-style shift registers. A pipelined Wishbone slave
// exposes a double-buffered framebuffer and control registers. Each row uses 2^PWM_BITS sub-scans for brightness.
module matrix_pwm_driver #(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int CLK_DIV  = 4,
    parameter int PWM_BITS = 4,
    localparam int WPR     = COLS / 8,
    localparam int AW      = $clog2(ROWS * WPR) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          o_matrix_clk,
    output logic          o_matrix_latch,
    output logic          o_matrix_mosi,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [3:0]    i_wb_sel,
    input  logic [31:0]   i_wb_wdata,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic [31:0]   o_wb_rdata,
    output logic [7:0]    o_frame_cnt
);
    localparam int WA    = AW - 1;
    localparam int DEPTH = 2 ** WA;
    localparam int N     = 3 * COLS + ROWS;
    localparam int RW    = $clog2(ROWS);
    localparam int LW    = $clog2(WPR + 1) + 1;
    localparam int BW    = $clog2(N);
    localparam int DW    = $clog2(CLK_DIV) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_LATCH} state_t;

    state_t                state_r, next_state_s;
    logic [31:0]           fb_mem_r [0:2*DEPTH-1];
    logic [31:0]           rd_data_r;
    logic [31:0]           row_words_r [0:WPR-1];
    logic [31:0]           row_words_s [0:WPR-1];
    logic [N-1:0]          image_s, shift_r;
    logic [RW-1:0]         row_r;
    logic [PWM_BITS-1:0]   k_r, brightness_r;
    logic [LW-1:0]         load_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DW-1:0]         div_cnt_r;
    logic                  phase_r;
    logic                  clk_r, latch_r, mosi_r;
    logic                  enable_r, swap_pending_r, front_r;
    logic [7:0]            frame_cnt_r;
    logic                  ack_r;
    logic [31:0]           rdata_r, rd_mux_s;
    logic                  half_done_s, last_bit_s, frame_end_s, swap_now_s, off_s;
    logic                  req_s, is_reg_s, bus_mem_wr_s, ctrl_wr_s;
    logic [WA-1:0]         word_addr_s, disp_addr_s;
    logic [WA:0]           back_idx_s, disp_idx_s;

    assign req_s        = i_wb_cyc & i_wb_stb;
    assign is_reg_s     = i_wb_addr[AW-1];
    assign word_addr_s  = i_wb_addr[WA-1:0];
    assign bus_mem_wr_s = req_s & i_wb_we & ~is_reg_s;
    assign ctrl_wr_s    = req_s & i_wb_we & is_reg_s & (word_addr_s == WA'(0));
    assign back_idx_s   = {~front_r, word_addr_s};
    assign disp_addr_s  = WA'(int'(row_r) * WPR + int'(load_cnt_r));
    assign disp_idx_s   = {front_r, disp_addr_s};

    assign half_done_s  = (div_cnt_r == DW'(CLK_DIV - 1));
    assign last_bit_s   = (bit_cnt_r == BW'(N - 1));
    assign frame_end_s  = (state_r == ST_LATCH) && half_done_s &&
                          (k_r == {PWM_BITS{1'b1}}) && (row_r == RW'(ROWS - 1));
    assign swap_now_s   = swap_pending_r && ((state_r == ST_IDLE) || frame_end_s);
    assign off_s        = (k_r >= brightness_r);

    assign o_matrix_clk   = clk_r;
    assign o_matrix_latch = latch_r;
    assign o_matrix_mosi  = mosi_r;
    assign o_wb_ack       = ack_r;
    assign o_wb_stall     = 1'b0;
    assign o_wb_rdata     = rdata_r;
    assign o_frame_cnt    = frame_cnt_r;

    // Framebuffer storage: byte-masked bus writes to the back bank, registered display read of the front bank
    always_ff @(posedge clk) begin
        if (bus_mem_wr_s) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    fb_mem_r[back_idx_s][8*b +: 8] <= i_wb_wdata[8*b +: 8];
                end
            end
        end
        rd_data_r <= fb_mem_r[disp_idx_s];
    end

    // The final word of a row is taken straight from the RAM output so LOAD stays WPR+1 cycles
    always_comb begin
        for (int w = 0; w < WPR; w++) begin
            if (w == WPR - 1) begin
                row_words_s[w] = rd_data_r;
            end else begin
                row_words_s[w] = row_words_r[w];
            end
        end
    end

    // Row image: R, G, B (active-low, MSB column first) followed by the active-high row one-hot
    always_comb begin
        image_s = '0;
        for (int c = 0; c < COLS; c++) begin
            image_s[2*COLS + ROWS + c] = off_s | ~row_words_s[c/8][4*(c%8) + 2];
            image_s[COLS + ROWS + c]   = off_s | ~row_words_s[c/8][4*(c%8) + 1];
            image_s[ROWS + c]          = off_s | ~row_words_s[c/8][4*(c%8)];
        end
        for (int r = 0; r < ROWS; r++) begin
            image_s[r] = (row_r == RW'(r));
        end
    end

    // Bus read data selection
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (!is_reg_s) begin
            rd_mux_s = fb_mem_r[back_idx_s];
        end else if (word_addr_s == WA'(0)) begin
            rd_mux_s[0]              = enable_r;
            rd_mux_s[8 +: PWM_BITS]  = brightness_r;
        end else if (word_addr_s == WA'(1)) begin
            rd_mux_s[0]    = swap_pending_r;
            rd_mux_s[15:8] = frame_cnt_r;
        end else begin
            rd_mux_s = 32'h0000_0000;
        end
    end

    // Wishbone response: every accepted request is acked on the following cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_r   <= 1'b0;
            rdata_r <= 32'h0000_0000;
        end else begin
            ack_r <= req_s;
            if (req_s && !i_wb_we) begin
                rdata_r <= rd_mux_s;
            end else begin
                rdata_r <= 32'h0000_0000;
            end
        end
    end

    // Control registers, bank selection and frame counter; a bus swap request wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_r       <= 1'b0;
            brightness_r   <= {PWM_BITS{1'b1}};
            swap_pending_r <= 1'b0;
            front_r        <= 1'b0;
            frame_cnt_r    <= 8'd0;
        end else begin
            if (swap_now_s) begin
                front_r        <= ~front_r;
                swap_pending_r <= 1'b0;
            end
            if (frame_end_s) begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
            end
            if (ctrl_wr_s) begin
                if (i_wb_sel[0]) begin
                    enable_r <= i_wb_wdata[0];
                    if (i_wb_wdata[1]) begin
                        swap_pending_r <= 1'b1;
                    end
                end
                if (i_wb_sel[1]) begin
                    brightness_r <= i_wb_wdata[8 +: PWM_BITS];
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable_r) next_state_s = ST_LOAD;
                else          next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (load_cnt_r == LW'(WPR)) next_state_s = ST_SHIFT;
                else                        next_state_s = ST_LOAD;
            end
            ST_SHIFT: begin
                if (half_done_s && phase_r && last_bit_s) next_state_s = ST_LATCH;
                else                                      next_state_s = ST_SHIFT;
            end
            ST_LATCH: begin
                if (!half_done_s)  next_state_s = ST_LATCH;
                else if (enable_r) next_state_s = ST_LOAD;
                else               next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Scan datapath: row fetch, serial shifting, latch pulse and row/sub-scan sequencing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_r      <= 1'b0;
            latch_r    <= 1'b0;
            mosi_r     <= 1'b0;
            row_r      <= '0;
            k_r        <= '0;
            load_cnt_r <= '0;
            bit_cnt_r  <= '0;
            div_cnt_r  <= '0;
            phase_r    <= 1'b0;
            shift_r    <= '0;
            for (int w = 0; w < WPR; w++) row_words_r[w] <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clk_r      <= 1'b0;
                    latch_r    <= 1'b0;
                    mosi_r     <= 1'b0;
                    row_r      <= '0;
                    k_r        <= '0;
                    load_cnt_r <= '0;
                end
                ST_LOAD: begin
                    load_cnt_r <= load_cnt_r + 1'b1;
                    for (int w = 0; w < WPR; w++) begin
                        if (load_cnt_r == LW'(w + 1)) row_words_r[w] <= rd_data_r;
                    end
                    if (load_cnt_r == LW'(WPR)) begin
                        mosi_r    <= image_s[N-1];
                        shift_r   <= {image_s[N-2:0], 1'b0};
                        bit_cnt_r <= '0;
                        div_cnt_r <= '0;
                        phase_r   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!half_done_s) begin
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end else begin
                        div_cnt_r <= '0;
                        if (!phase_r) begin
                            clk_r   <= 1'b1;
                            phase_r <= 1'b1;
                        end else begin
                            clk_r   <= 1'b0;
                            phase_r <= 1'b0;
                            if (last_bit_s) begin
                                latch_r <= 1'b1;
                            end else begin
                                mosi_r    <= shift_r[N-1];
                                shift_r   <= {shift_r[N-2:0], 1'b0};
                                bit_cnt_r <= bit_cnt_r + 1'b1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (!half_done_s) begin
                        div_cnt_r <= div_cnt_r + 1'b1;
                    end else begin
                        latch_r    <= 1'b0;
                        div_cnt_r  <= '0;
                        load_cnt_r <= '0;
                        k_r        <= k_r + 1'b1;
                        if (k_r == {PWM_BITS{1'b1}}) begin
                            if (row_r == RW'(ROWS - 1)) row_r <= '0;
                            else                        row_r <= row_r + 1'b1;
                        end
                    end
                end
                default: begin
                    clk_r   <= 1'b0;
                    latch_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_pwm_driver.sv
// Scoreboard bench for matrix_pwm_driver: bus responses and decoded row images are checked
// against expectations queued by the stimulus.
module tb_matrix_pwm_driver;
    localparam int N     = 32;
    localparam int SUB   = 262;
    localparam int FRAME = 8 * 16 * 262;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        o_matrix_clk, o_matrix_latch, o_matrix_mosi;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_addr = 4'h0;
    logic [3:0]  wb_sel = 4'h0;
    logic [31:0] wb_wdata = 32'h0;
    logic        o_wb_ack, o_wb_stall;
    logic [31:0] o_wb_rdata;
    logic [7:0]  o_frame_cnt;

    matrix_pwm_driver dut (
        .clk(clk), .reset_n(reset_n),
        .o_matrix_clk(o_matrix_clk), .o_matrix_latch(o_matrix_latch), .o_matrix_mosi(o_matrix_mosi),
        .i_wb_cyc(wb_cyc), .i_wb_stb(wb_stb), .i_wb_we(wb_we), .i_wb_addr(wb_addr),
        .i_wb_sel(wb_sel), .i_wb_wdata(wb_wdata),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_rdata(o_wb_rdata),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] exp;
        int          t;
    } wb_exp_t;

    wb_exp_t     wq[$];
    logic [31:0] iq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_n = 0;
    int          mclk_rises = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int waited);
        total++;
        bad++;
        $display("FAIL %s: actual=timeout after %0d cycles required=condition reached", name, waited);
    endtask

    // Entered and left at posedge+1; the request is accepted on the next posedge
    task automatic wb_op(input logic we, input logic [3:0] addr, input logic [3:0] sel,
                         input logic [31:0] wd, input logic [31:0] exp);
        wb_exp_t e;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_sel = sel; wb_wdata = wd;
        e.we = we; e.exp = exp; e.t = cyc_n;
        wq.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic wb_end();
        int n;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        n = 0;
        while (wq.size() > 0 && n < 10) begin
            @(posedge clk); #1; n++;
        end
        if (wq.size() > 0) timeout_fail("wb_ack_wait", n);
    endtask

    task automatic wait_img(input int target, input int budget);
        int n;
        n = 0;
        while (iq.size() > target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (iq.size() > target) timeout_fail("image_wait", n);
    endtask

    function automatic logic [31:0] img_f0(input int r, input int k);
        logic [7:0] red;
        red = (r == 0 && k < 4) ? 8'hFE : 8'hFF;
        return {red, 8'hFF, 8'hFF, 8'(1 << r)};
    endfunction

    function automatic logic [31:0] img_f1(input int r, input int k);
        logic [7:0] oh;
        oh = 8'(1 << r);
        if (k >= 4)      return {24'hFFFFFF, oh};
        else if (r == 0) return {8'hFF, 8'hFE, 8'hFF, oh};
        else if (r < 4)  return {24'hFFFFFF, oh};
        else             return {8'hE0, 8'h9F, 8'h50, oh};
    endfunction

    // Bus monitor: pops one expectation per ack and checks its timing and read data
    always @(negedge clk) begin
        wb_exp_t e;
        if (reset_n) begin
            if (o_wb_ack) begin
                if (wq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected_ack: actual=ack required=no ack");
                end else begin
                    e = wq.pop_front();
                    check("wb_ack_time", 32'(cyc_n), 32'(e.t + 1));
                    if (!e.we) check("wb_rdata", o_wb_rdata, e.exp);
                end
            end else begin
                check("wb_idle_bus", {o_wb_stall, o_wb_rdata}, 32'h0);
            end
        end
    end

    // Matrix monitor: decodes bits on shift-clock rises and checks each latched row image
    logic [N-1:0] img = '0;
    int bitcnt = 0, last_latch_t = -1, latch_w = 0;
    logic prev_mclk = 1'b0, prev_latch = 1'b0;
    always @(negedge clk) begin
        if (!reset_n) begin
            bitcnt = 0; last_latch_t = -1; latch_w = 0;
            prev_mclk = 1'b0; prev_latch = 1'b0;
        end else begin
            if (o_matrix_clk && !prev_mclk) begin
                img = {img[N-2:0], o_matrix_mosi};
                bitcnt++;
                mclk_rises++;
            end
            if (o_matrix_latch && !prev_latch) begin
                check("image_bits", 32'(bitcnt), 32'(N));
                if (iq.size() > 0) check("row_image", img, iq.pop_front());
                if (last_latch_t >= 0) check("subscan_len", 32'(cyc_n - last_latch_t), 32'(SUB));
                last_latch_t = cyc_n;
                bitcnt = 0;
                latch_w = 1;
            end else if (o_matrix_latch) begin
                latch_w++;
            end
            if (!o_matrix_latch && prev_latch) check("latch_width", 32'(latch_w), 32'd4);
            prev_mclk = o_matrix_clk;
            prev_latch = o_matrix_latch;
        end
    end

    // Frame counter monitor: checks step size and spacing between increments
    logic [7:0] prev_fc = 8'd0;
    int fc_t = -1;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_fc = 8'd0; fc_t = -1;
        end else if (o_frame_cnt != prev_fc) begin
            check("frame_cnt_step", {24'h0, o_frame_cnt}, {24'h0, prev_fc + 8'd1});
            if (fc_t >= 0) check("frame_len", 32'(cyc_n - fc_t), 32'(FRAME));
            fc_t = cyc_n;
            prev_fc = o_frame_cnt;
        end
    end

    initial begin
        int n, r0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs", {28'h0, o_matrix_clk, o_matrix_latch, o_matrix_mosi, o_wb_ack}, 32'h0);
        check("reset_frame_cnt", {24'h0, o_frame_cnt}, 32'h0);

        wb_op(1'b0, 4'h9, 4'hF, 32'h0, 32'h0000_0000);
        wb_op(1'b0, 4'h8, 4'hF, 32'h0, 32'h0000_0F00);
        wb_end();

        wb_op(1'b1, 4'h0, 4'hF, 32'h0000_0004, 32'h0);
        for (int w = 1; w < 8; w++) wb_op(1'b1, 4'(w), 4'hF, 32'h0, 32'h0);
        wb_end();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 16; k++) iq.push_back(img_f0(r, k));
        wb_op(1'b1, 4'h8, 4'hF, 32'h0000_0F03, 32'h0);
        wb_end();

        wait_img(127, 2000);
        wb_op(1'b1, 4'h8, 4'hF, 32'h0000_0401, 32'h0);
        wb_op(1'b1, 4'h0, 4'hF, 32'h0000_0002, 32'h0);
        for (int w = 1; w < 4; w++) wb_op(1'b1, 4'(w), 4'hF, 32'h0, 32'h0);
        for (int w = 4; w < 8; w++) wb_op(1'b1, 4'(w), 4'hF, 32'h1234_5678, 32'h0);
        for (int w = 4; w < 8; w++) wb_op(1'b1, 4'(w), 4'h3, 32'hAAAA_5555, 32'h0);
        for (int w = 4; w < 8; w++) wb_op(1'b0, 4'(w), 4'hF, 32'h0, 32'h1234_5555);
        wb_op(1'b0, 4'h0, 4'hF, 32'h0, 32'h0000_0002);
        wb_op(1'b1, 4'h8, 4'hF, 32'h0000_0403, 32'h0);
        wb_op(1'b0, 4'h9, 4'hF, 32'h0, 32'h0000_0001);
        wb_end();
        for (int r = 0; r < 8; r++)
            for (int k = 0; k < 16; k++) iq.push_back(img_f1(r, k));

        wait_img(127, 40000);
        wb_op(1'b0, 4'h9, 4'hF, 32'h0, 32'h0000_0100);
        wb_end();

        wait_img(0, 40000);
        n = 0;
        while (o_frame_cnt != 8'd2 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        check("frame_cnt_after_two", {24'h0, o_frame_cnt}, 32'd2);

        n = 0;
        while (!o_matrix_clk && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        check("pre_reset_shift", {30'h0, o_matrix_clk, o_matrix_mosi}, 32'h3);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_pins", {29'h0, o_matrix_clk, o_matrix_latch, o_matrix_mosi}, 32'h0);
        check("async_reset_frame_cnt", {24'h0, o_frame_cnt}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        wb_op(1'b0, 4'h8, 4'hF, 32'h0, 32'h0000_0F00);
        wb_op(1'b0, 4'h9, 4'hF, 32'h0, 32'h0000_0000);
        wb_end();
        r0 = mclk_rises;
        repeat (600) @(posedge clk);
        #1;
        check("idle_no_shift", 32'(mclk_rises), 32'(r0));
        check("idle_pins", {29'h0, o_matrix_clk, o_matrix_latch, o_matrix_mosi}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/matrix_pwm_driver.md
Name: matrix_pwm_driver

Overview:
- Parametrised successor to the 8x8 RGB matrix driver.
- Drives a ROWS x COLS common-anode RGB matrix built from daisy-chained 595-style shift registers, using three outputs: shift clock, latch and serial data.
- Exposes a double-buffered framebuffer and control registers through a pipelined Wishbone slave with byte select.
- Adds global PWM brightness, frame-synchronous buffer swap and a frame counter; sits between a Wishbone master (e.g. move_master) and the board pins.

Parameters:
- ROWS, 8: number of matrix rows, 2..32.
- COLS, 8: number of matrix columns; must be a multiple of 8. WPR = COLS/8 words per row.
- CLK_DIV, 4: clk cycles per shift-clock half period and per latch pulse; must be at least 1.
- PWM_BITS, 4: width of the brightness setting; 2^PWM_BITS sub-scans are run per row.

Ports:
- clk, input, 1: single system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- o_matrix_clk, output, 1: shift clock; data is sampled by the shift registers on its rising edge.
- o_matrix_latch, output, 1: output latch strobe, active high.
- o_matrix_mosi, output, 1: serial shift data.
- i_wb_cyc, i_wb_stb, i_wb_we, input, 1 each: Wishbone control.
- i_wb_addr, input, AW = clog2(ROWS*WPR)+1: Wishbone address.
- i_wb_sel, input, 4: byte select.
- i_wb_wdata, input, 32: write data.
- o_wb_ack, output, 1: Wishbone acknowledge.
- o_wb_stall, output, 1: Wishbone stall.
- o_wb_rdata, output, 32: read data.
- o_frame_cnt, output, 8: completed-frame counter, wraps.

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Bank 0 is the front buffer; swap_pending = 0.
  - enable = 0; brightness = all ones.
  - Framebuffer RAM is not reset; it must be written before use.
- Pixel format:
  - Each 32-bit word holds 8 pixels as nibbles [.RGB].
  - Pixel p of a word is in bits [4p+2:4p]: bit 2 = R, bit 1 = G, bit 0 = B.
  - Bit 3 of each nibble is stored but ignored by the display.
  - Word index = row*WPR + column/8.
- Address map:
  - addr[AW-1] = 0: back-buffer word addr[AW-2:0], read/write.
  - addr[AW-1] = 1, offset 0, CTRL: bit0 enable; bit1 swap request (write 1 sets swap_pending, reads as 0); bits [8+PWM_BITS-1:8] brightness.
  - addr[AW-1] = 1, offset 1, STATUS (read-only): bit0 swap_pending; bits [15:8] frame count.
  - All other offsets read 0; writes to them are ignored.
- Wishbone:
  - o_wb_stall is always 0.
  - Each cycle with cyc & stb is accepted.
  - o_wb_ack is high exactly one cycle later, for exactly one cycle per accepted request.
  - o_wb_rdata is valid while ack is high and is 0 otherwise.
  - i_wb_sel masks byte writes to framebuffer words and to CTRL.
  - Back-to-back requests are acked every cycle.
  - If cyc drops, any pending ack is still issued.
- Row image (shift order, first bit shifted first, MSB first in each group):
  - Red bits for columns COLS-1..0.
  - Then green bits for columns COLS-1..0.
  - Then blue bits for columns COLS-1..0.
  - Then the row-select one-hot, ROWS-1..0.
  - Colour bits are active-low (0 = LED on). Row-select is active-high.
  - Total row image length N = 3*COLS + ROWS bits.
- FSM:
  - IDLE:
    - Outputs low.
    - A pending swap is applied immediately.
    - Leaves IDLE when enable = 1, starting at row 0, sub-scan 0.
  - LOAD:
    - Takes WPR+1 cycles: synchronous reads of the row's words from the front bank.
    - Builds the N-bit shift image.
    - If sub-scan index k is not less than brightness, all colour bits are forced to 1 (off); row-select is still driven.
  - SHIFT:
    - Per bit: mosi is updated with o_matrix_clk low; clk is held low CLK_DIV cycles, then high CLK_DIV cycles.
    - Repeats for N bits.
  - LATCH:
    - o_matrix_clk = 0; o_matrix_latch high for CLK_DIV cycles.
    - mosi holds its last value.
    - Then advances k. On k wrap, advances the row.
    - On row wrap (frame end): o_frame_cnt increments; if swap_pending, banks swap and swap_pending clears, in the same cycle.
    - If enable = 0 at this point, goes to IDLE; otherwise goes to LOAD.
- Sub-scan length = (WPR+1) + 2*CLK_DIV*N + CLK_DIV cycles. Defaults: 2 + 256 + 4 = 262.
- Frame length = ROWS * 2^PWM_BITS sub-scans.
- Brightness is sampled in LOAD, so a change takes effect at the next sub-scan.
- Brightness = 0 shifts all-off colour data.
- Clearing enable mid-row completes the current sub-scan through LATCH, then goes to IDLE.
- Wishbone writes never touch the front bank.
- Asserting reset_n mid-shift drives the outputs low immediately.

Test Plan:
- Reset, then an idle Wishbone read of STATUS → ack one cycle after stb; rdata = 0x00000000; all matrix outputs 0.
- Write word 0 = 0x00000004 (pixel 0 red), brightness 15, swap, enable → the first row-0 image decoded on o_matrix_clk rising edges has red bits 0xFE (col 0 on), green 0xFF, blue 0xFF, row 0x01; the latch pulse is 4 cycles wide; the sub-scan spans 262 cycles.
- Brightness 4 → within each row, sub-scans 0-3 carry pixel data and sub-scans 4-15 carry colour bits 0xFF; o_frame_cnt increments once every 8*16*262 cycles.
- Write the back buffer mid-frame with swap requested → the front data is unchanged until the frame end; STATUS bit0 = 1 until the swap, then 0; the next frame shows the new data.
- Back-to-back pipelined writes to 4 words with sel = 4'b0011 → 4 consecutive acks; read-back shows only the low 16 bits updated.
- Pulse reset_n low mid-SHIFT → clk, latch, mosi and o_frame_cnt are 0 asynchronously; after release, enable reads 0 and the FSM stays in IDLE.
